gray_counter_param: RTL and testbench

Parametrised up/down Gray-code counter. It is the successor to the fixed 8-bit up-only Gray counter.
Adds configurable width, direction control, a parallel load in Gray format, and a wrap or saturate mode with terminal-count flags.
Gray and binary outputs are both registered, so no combinational glitches reach downstream clock-domain-crossing synchronisers.
Used as a pointer generator for async FIFOs and as a general event counter.

---
 rtl/gray_pkg.sv | 21 ++
 rtl/gray_to_bin.sv | 13 +
 rtl/gray_counter_param.sv | 86 ++++++++
 tb/tb_gray_counter_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for the Gray counter and async FIFO pointer logic.
// Arguments are zero-extended to GRAY_MAX_WIDTH; callers truncate results to their own width.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the low bits unaffected.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter, shared by the counter load path and FIFO pointer compare.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with Gray-format load, wrap/saturate mode and terminal flags.
// Every output is a flop so downstream synchronisers never see decode glitches.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int          SATURATE = 0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_VAL)));
  localparam bit               SAT_EN   = (SATURATE != 0);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_sum;
  logic             wrap_next;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_gray),
    .bin  (load_bin)
  );

  // The carry/borrow out of the extra bit doubles as the max/zero boundary detect.
  assign inc_sum = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_sum = {1'b0, cnt} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    cnt_next  = cnt;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = load_bin;
    end else if (enable) begin
      if (up) begin
        if (!inc_sum[WIDTH]) begin
          cnt_next = inc_sum[WIDTH-1:0];
        end else if (!SAT_EN) begin
          cnt_next  = inc_sum[WIDTH-1:0];
          wrap_next = 1'b1;
        end
      end else begin
        if (!dec_sum[WIDTH]) begin
          cnt_next = dec_sum[WIDTH-1:0];
        end else if (!SAT_EN) begin
          cnt_next  = dec_sum[WIDTH-1:0];
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= RST_BIN;
      gray_out <= RST_GRAY;
      at_max   <= (RST_BIN == MAX_VAL);
      at_min   <= (RST_BIN == '0);
      wrap     <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      gray_out <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(cnt_next)));
      at_max   <= (cnt_next == MAX_VAL);
      at_min   <= (cnt_next == '0);
      wrap     <= wrap_next;
    end
  end

  assign bin_out = cnt;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench: four counter configurations run in lockstep against an integer reference model.
module tb_gray_counter_param;

  typedef struct {
    int         id;
    logic [7:0] gray;
    logic [7:0] bin;
    logic       amax;
    logic       amin;
    logic       wrp;
    int         flips;
  } exp_t;

  localparam int WD [4]  = '{4, 4, 8, 4};
  localparam int SAT [4] = '{0, 1, 0, 0};
  localparam int RV [4]  = '{0, 0, 0, 3};

  logic       clk;
  logic       rst;
  logic       enable;
  logic       up;
  logic       load;
  logic [3:0] lg4;
  logic [7:0] lg8;

  logic [3:0] g0, b0, g1, b1, g3, b3;
  logic [7:0] g2, b2;
  logic       mx0, mn0, wr0, mx1, mn1, wr1, mx2, mn2, wr2, mx3, mn3, wr3;

  exp_t       sb [$];
  int         mbin [4];
  logic [7:0] prev_gray [4];
  int         tests;
  int         fails;

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(0)) u_d0 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_gray(lg4),
    .gray_out(g0), .bin_out(b0), .at_max(mx0), .at_min(mn0), .wrap(wr0));
  gray_counter_param #(.WIDTH(4), .SATURATE(1), .RST_VAL(0)) u_d1 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_gray(lg4),
    .gray_out(g1), .bin_out(b1), .at_max(mx1), .at_min(mn1), .wrap(wr1));
  gray_counter_param #(.WIDTH(8), .SATURATE(0), .RST_VAL(0)) u_d2 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_gray(lg8),
    .gray_out(g2), .bin_out(b2), .at_max(mx2), .at_min(mn2), .wrap(wr2));
  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_VAL(3)) u_d3 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .load(load), .load_gray(lg4),
    .gray_out(g3), .bin_out(b3), .at_max(mx3), .at_min(mn3), .wrap(wr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drainScoreboard();
    exp_t       x;
    logic [7:0] og, ob;
    logic       omx, omn, owr;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.id)
        0:       begin og = {4'b0, g0}; ob = {4'b0, b0}; omx = mx0; omn = mn0; owr = wr0; end
        1:       begin og = {4'b0, g1}; ob = {4'b0, b1}; omx = mx1; omn = mn1; owr = wr1; end
        2:       begin og = g2;         ob = b2;         omx = mx2; omn = mn2; owr = wr2; end
        default: begin og = {4'b0, g3}; ob = {4'b0, b3}; omx = mx3; omn = mn3; owr = wr3; end
      endcase
      checkOutput($sformatf("d%0d.gray", x.id), 32'(og), 32'(x.gray));
      checkOutput($sformatf("d%0d.bin", x.id), 32'(ob), 32'(x.bin));
      checkOutput($sformatf("d%0d.at_max", x.id), 32'(omx), 32'(x.amax));
      checkOutput($sformatf("d%0d.at_min", x.id), 32'(omn), 32'(x.amin));
      checkOutput($sformatf("d%0d.wrap", x.id), 32'(owr), 32'(x.wrp));
      if (x.flips >= 0)
        checkOutput($sformatf("d%0d.flips", x.id), 32'($countones(prev_gray[x.id] ^ og)), 32'(x.flips));
      prev_gray[x.id] = og;
    end
  endtask

  // Drives one cycle of stimulus, predicts every DUT's next outputs, then checks after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l, input int lb);
    exp_t x;
    int   maxv;
    int   b;
    rst    = r;
    enable = e;
    up     = u;
    load   = l;
    lg4    = 4'((lb & 15) ^ ((lb & 15) >> 1));
    lg8    = 8'((lb & 255) ^ ((lb & 255) >> 1));
    for (int i = 0; i < 4; i++) begin
      maxv    = (1 << WD[i]) - 1;
      b       = mbin[i];
      x.wrp   = 1'b0;
      x.flips = -1;
      if (!r) begin
        b = RV[i];
      end else if (l) begin
        b = lb & maxv;
      end else if (e && u) begin
        x.flips = 1;
        if (b != maxv) b = b + 1;
        else if (SAT[i] == 0) begin b = 0; x.wrp = 1'b1; end
        else x.flips = 0;
      end else if (e) begin
        x.flips = 1;
        if (b != 0) b = b - 1;
        else if (SAT[i] == 0) begin b = maxv; x.wrp = 1'b1; end
        else x.flips = 0;
      end else begin
        x.flips = 0;
      end
      mbin[i] = b;
      x.id    = i;
      x.bin   = 8'(b);
      x.gray  = 8'(b ^ (b >> 1));
      x.amax  = (b == maxv);
      x.amin  = (b == 0);
      sb.push_back(x);
    end
    @(posedge clk);
    @(negedge clk);
    drainScoreboard();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 4; i++) begin
      mbin[i]      = 0;
      prev_gray[i] = '0;
    end

    // Reset, then idle
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);

    // Full up sweep through the wrap
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);

    // Load 1, then count down past zero
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Count to 5, then load wins over enable
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h80);

    // Direction change at the max boundary
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 15);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Reset pulse mid-count, then resume
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
